// File: rtl/miriscv_lsu_pkg.sv
// Shared types and constants for the miriscv load/store unit.
// XLEN is kept here so the LSU slice compiles on its own.
package miriscv_lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: misalignment check, byte enables, store lane
// replication and load extraction with sign/zero extension.
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [XLEN-1:0] rdata,
    output logic            misaligned,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_ext
);

    logic        is_byte;
    logic        is_half;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Only the low two funct3 bits pick the width; the undefined codes
    // (011/110/111) fall through to the word case.
    assign is_byte   = (size[1:0] == MEM_B[1:0]);
    assign is_half   = (size[1:0] == MEM_H[1:0]);
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = wdata_in;
        rdata_ext  = rdata;
        if (is_byte) begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{wdata_in[7:0]}};
            rdata_ext = {{24{~size[2] & byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            misaligned = addr_lo[0];
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata      = {2{wdata_in[15:0]}};
            rdata_ext  = {{16{~size[2] & half_lane[15]}}, half_lane};
        end else begin
            misaligned = (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one OBI-style transaction per memory instruction,
// stalling the pipeline until the response arrives.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
(
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic            lsu_kill_i,
    output logic            lsu_stall_req_o,
    output logic            lsu_valid_o,
    output logic [XLEN-1:0] lsu_data_o,
    output logic            lsu_misaligned_o,
    output lsu_state_t      lsu_state_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i
);

    lsu_state_t      state, next_state;

    logic            we_q;
    logic [2:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [29:0]     word_addr_q;
    logic [XLEN-1:0] rdata_q;

    logic            st_misaligned;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_rdata;
    logic [XLEN-1:0] unused_st_rdata;
    logic            unused_ld_misaligned;
    logic [3:0]      unused_ld_be;
    logic [XLEN-1:0] unused_ld_wdata;

    logic            take;
    logic            accept;

    miriscv_lsu_align u_store_align (
        .size       (lsu_size_i),
        .addr_lo    (lsu_addr_i[1:0]),
        .wdata_in   (lsu_data_i),
        .rdata      ('0),
        .misaligned (st_misaligned),
        .be         (st_be),
        .wdata      (st_wdata),
        .rdata_ext  (unused_st_rdata)
    );

    miriscv_lsu_align u_load_align (
        .size       (size_q),
        .addr_lo    (addr_lo_q),
        .wdata_in   (wdata_q),
        .rdata      (data_rdata_i),
        .misaligned (unused_ld_misaligned),
        .be         (unused_ld_be),
        .wdata      (unused_ld_wdata),
        .rdata_ext  (ld_rdata)
    );

    assign take             = (state == IDLE) && lsu_req_i && !lsu_kill_i;
    assign accept           = take && !st_misaligned;
    assign lsu_misaligned_o = take && st_misaligned;

    always_comb begin
        next_state      = state;
        lsu_stall_req_o = 1'b0;
        lsu_valid_o     = 1'b0;
        data_req_o      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    lsu_stall_req_o = 1'b1;
                    next_state      = REQ;
                end
            end
            REQ: begin
                lsu_stall_req_o = 1'b1;
                data_req_o      = 1'b1;
                if (data_gnt_i) next_state = RSP;
            end
            RSP: begin
                lsu_stall_req_o = 1'b1;
                if (data_rvalid_i) next_state = DONE;
            end
            DONE: begin
                lsu_valid_o = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            word_addr_q <= '0;
            rdata_q     <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                we_q        <= lsu_we_i;
                size_q      <= lsu_size_i;
                addr_lo_q   <= lsu_addr_i[1:0];
                be_q        <= st_be;
                wdata_q     <= st_wdata;
                word_addr_q <= lsu_addr_i[31:2];
            end
            // Stores complete with a zero result so writeback never sees stale data.
            if (state == RSP && data_rvalid_i) begin
                rdata_q <= we_q ? '0 : ld_rdata;
            end
        end
    end

    assign lsu_data_o   = rdata_q;
    assign lsu_state_o  = state;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = {word_addr_q, 2'b00};
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: each scenario task drives the pipeline
// and memory side cycle by cycle and compares outputs inline.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'b000;
    logic [31:0] lsu_addr_i = 32'h0;
    logic [31:0] lsu_data_i = 32'h0;
    logic        lsu_kill_i = 1'b0;
    logic        lsu_stall_req_o;
    logic        lsu_valid_o;
    logic [31:0] lsu_data_o;
    logic        lsu_misaligned_o;
    logic [1:0]  lsu_state_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    miriscv_lsu dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_data_i       (lsu_data_i),
        .lsu_kill_i       (lsu_kill_i),
        .lsu_stall_req_o  (lsu_stall_req_o),
        .lsu_valid_o      (lsu_valid_o),
        .lsu_data_o       (lsu_data_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .lsu_state_o      (lsu_state_o),
        .data_req_o       (data_req_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        settle();
        checks++;
        if ({lsu_stall_req_o, lsu_valid_o, lsu_misaligned_o, data_req_o, data_we_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {lsu_stall_req_o, lsu_valid_o, lsu_misaligned_o, data_req_o, data_we_o});
        end
        checks++;
        if ({lsu_data_o, data_addr_o, data_wdata_o, data_be_o} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     lsu_data_o, data_addr_o, data_wdata_o, data_be_o);
        end
        tick();
        arstn_i = 1'b1;
    endtask

    task automatic test_store_word();
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_1008; lsu_data_i = 32'hDEAD_BEEF;
        settle();
        checks++;
        if ({lsu_stall_req_o, data_req_o} !== 2'b10) begin
            errors++;
            $display("FAIL sw_accept: stall/req %b expected 10", {lsu_stall_req_o, data_req_o});
        end
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b1;
        settle();
        checks++;
        if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_stall_req_o}
            !== {1'b1, 1'b1, 4'b1111, 32'h0000_1008, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL sw_req: req %b we %b be %b addr %h wdata %h stall %b expected 1 1 1111 00001008 deadbeef 1",
                     data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_stall_req_o);
        end
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        settle();
        checks++;
        if ({lsu_stall_req_o, data_req_o, lsu_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL sw_rsp: stall/req/valid %b expected 100",
                     {lsu_stall_req_o, data_req_o, lsu_valid_o});
        end
        tick();
        data_rvalid_i = 1'b0;
        settle();
        checks++;
        if ({lsu_valid_o, lsu_stall_req_o, lsu_data_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL sw_done: valid %b stall %b data %h expected 1 0 00000000",
                     lsu_valid_o, lsu_stall_req_o, lsu_data_o);
        end
        tick();
        settle();
        checks++;
        if (lsu_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_pulse: valid %b expected 0", lsu_valid_o);
        end
    endtask

    task automatic run_load(input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = size; lsu_addr_i = addr;
        settle();
        checks++;
        if (lsu_stall_req_o !== 1'b1) begin
            errors++;
            $display("FAIL ld_accept: stall %b expected 1 (size %b addr %h)", lsu_stall_req_o, size, addr);
        end
        tick();
        data_gnt_i = 1'b1;
        settle();
        checks++;
        if ({data_req_o, data_we_o, data_be_o, data_addr_o} !== {1'b1, 1'b0, exp_be, addr & 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL ld_req: req %b we %b be %b addr %h expected 1 0 %b %h",
                     data_req_o, data_we_o, data_be_o, data_addr_o, exp_be, addr & 32'hFFFF_FFFC);
        end
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rdata;
        // lsu_req_i stays high into DONE, where it must be ignored.
        tick();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        settle();
        checks++;
        if ({lsu_valid_o, lsu_data_o} !== {1'b1, exp_data}) begin
            errors++;
            $display("FAIL ld_data: valid %b data %h expected 1 %h (size %b addr %h)",
                     lsu_valid_o, lsu_data_o, exp_data, size, addr);
        end
        tick();
        lsu_req_i = 1'b0;
        settle();
        checks++;
        if ({lsu_valid_o, data_req_o, lsu_stall_req_o, lsu_data_o} !== {3'b000, exp_data}) begin
            errors++;
            $display("FAIL ld_after: valid/req/stall %b data %h expected 000 %h",
                     {lsu_valid_o, data_req_o, lsu_stall_req_o}, lsu_data_o, exp_data);
        end
    endtask

    task automatic test_loads();
        run_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        run_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
        run_load(3'b001, 32'h0000_0102, 32'h8001_7F00, 4'b1100, 32'hFFFF_8001);
        run_load(3'b101, 32'h0000_0102, 32'h8001_7F00, 4'b1100, 32'h0000_8001);
        run_load(3'b000, 32'h0000_0101, 32'h1234_7F56, 4'b0010, 32'h0000_007F);
        run_load(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        run_load(3'b111, 32'h0000_0108, 32'h8765_4321, 4'b1111, 32'h8765_4321);
    endtask

    task automatic test_misaligned();
        logic seen_req;
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b001; lsu_addr_i = 32'h0000_0101;
        settle();
        checks++;
        if ({lsu_misaligned_o, lsu_stall_req_o, data_req_o} !== 3'b100) begin
            errors++;
            $display("FAIL lh_misalign: mis/stall/req %b expected 100",
                     {lsu_misaligned_o, lsu_stall_req_o, data_req_o});
        end
        seen_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            seen_req |= data_req_o;
        end
        checks++;
        if (seen_req !== 1'b0) begin
            errors++;
            $display("FAIL lh_noreq: data_req seen %b expected 0", seen_req);
        end
        lsu_size_i = 3'b010; lsu_addr_i = 32'h0000_0102;
        settle();
        checks++;
        if ({lsu_misaligned_o, lsu_stall_req_o} !== 2'b10) begin
            errors++;
            $display("FAIL lw_misalign: mis/stall %b expected 10", {lsu_misaligned_o, lsu_stall_req_o});
        end
        lsu_kill_i = 1'b1;
        settle();
        checks++;
        if (lsu_misaligned_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_killed: mis %b expected 0", lsu_misaligned_o);
        end
        tick();
        lsu_req_i = 1'b0; lsu_kill_i = 1'b0;
    endtask

    task automatic test_store_half_delay();
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'b001;
        lsu_addr_i = 32'h0000_0202; lsu_data_i = 32'h1234_ABCD;
        tick();
        lsu_req_i = 1'b0; lsu_addr_i = 32'h0; lsu_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}
                !== {1'b1, 1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD}) begin
                errors++;
                $display("FAIL sh_hold%0d: req %b we %b be %b addr %h wdata %h expected 1 1 1100 00000200 abcdabcd",
                         i, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o);
            end
            tick();
        end
        data_gnt_i = 1'b1;
        settle();
        checks++;
        if ({data_req_o, data_be_o} !== {1'b1, 4'b1100}) begin
            errors++;
            $display("FAIL sh_gnt: req %b be %b expected 1 1100", data_req_o, data_be_o);
        end
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        settle();
        checks++;
        if ({lsu_valid_o, lsu_data_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL sh_done: valid %b data %h expected 1 00000000", lsu_valid_o, lsu_data_o);
        end
    endtask

    task automatic test_kill();
        tick();
        lsu_req_i = 1'b1; lsu_kill_i = 1'b1; lsu_we_i = 1'b0;
        lsu_size_i = 3'b010; lsu_addr_i = 32'h0000_0300;
        settle();
        checks++;
        if ({lsu_stall_req_o, lsu_misaligned_o} !== 2'b00) begin
            errors++;
            $display("FAIL kill_idle: stall/mis %b expected 00", {lsu_stall_req_o, lsu_misaligned_o});
        end
        tick();
        lsu_req_i = 1'b0; lsu_kill_i = 1'b0;
        settle();
        checks++;
        if ({data_req_o, lsu_stall_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL kill_noreq: req/stall %b expected 00", {data_req_o, lsu_stall_req_o});
        end
        lsu_req_i = 1'b1;
        tick();
        lsu_req_i = 1'b0; lsu_kill_i = 1'b1;
        tick();
        data_gnt_i = 1'b1;
        settle();
        checks++;
        if (data_req_o !== 1'b1) begin
            errors++;
            $display("FAIL kill_req_held: req %b expected 1", data_req_o);
        end
        tick();
        data_gnt_i = 1'b0; lsu_kill_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1122_3344;
        tick();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        settle();
        checks++;
        if ({lsu_valid_o, lsu_data_o} !== {1'b1, 32'h1122_3344}) begin
            errors++;
            $display("FAIL kill_complete: valid %b data %h expected 1 11223344", lsu_valid_o, lsu_data_o);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'b000;
        lsu_addr_i = 32'h0000_0401; lsu_data_i = 32'h0000_00A5;
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        settle();
        arstn_i = 1'b0;
        #1;
        checks++;
        if ({lsu_stall_req_o, lsu_valid_o, data_req_o, data_we_o, data_be_o,
             data_addr_o, data_wdata_o, lsu_data_o} !== 104'h0) begin
            errors++;
            $display("FAIL rst_mid: stall %b valid %b req %b we %b be %b addr %h wdata %h data %h expected all zero",
                     lsu_stall_req_o, lsu_valid_o, data_req_o, data_we_o, data_be_o,
                     data_addr_o, data_wdata_o, lsu_data_o);
        end
        tick();
        arstn_i = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            data_rvalid_i = 1'b0;
            settle();
            seen_valid |= lsu_valid_o;
        end
        checks++;
        if ({seen_valid, lsu_stall_req_o, lsu_data_o} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_stray: valid seen %b stall %b data %h expected 0 0 00000000",
                     seen_valid, lsu_stall_req_o, lsu_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_misaligned();
        test_store_half_delay();
        test_kill();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
